ms_stopwatch: RTL and testbench
===============================

// Module: ms_stopwatch
// PURPOSE
//  Consumer of the 1 kHz square-wave timebase produced by the ms clock divider.
//  Synchronises the timebase into clk_27Mhz and detects its rising edges.
//  Runs a start/stop/lap/clear stopwatch (min:sec:ms) and drives registered display values for the FPWW display path.
//  Sits between the divider output and the display/segment driver.
// PARAMETERS
//  MS_MAX   999  last ms value before roll to sec
//  SEC_MAX  59   last sec value before roll to min
//  MIN_MAX  59   last min value before full wrap to 00:00.000
// PORTS
//  clk_27Mhz   in   1   system clock; all logic on posedge
//  rst         in   1   synchronous, active-high reset
//  tick_in     in   1   1 kHz square wave from divider (any phase, >=2 cycles high/low)
//  start_stop  in   1   1-cycle pulse: toggle run/pause
//  lap         in   1   1-cycle pulse: freeze/unfreeze display
//  clear       in   1   1-cycle pulse: return to zero, stop
//  disp_ms     out  10  displayed ms, 0..MS_MAX
//  disp_sec    out  6   displayed seconds, 0..SEC_MAX
//  disp_min    out  6   displayed minutes, 0..MIN_MAX
//  running     out  1   1 in RUN or LAP
//  lap_active  out  1   1 in LAP (display frozen)
//  wrap        out  1   1-cycle pulse on MIN_MAX:SEC_MAX:MS_MAX -> 0 roll
// BEHAVIOUR
//  Reset: state=IDLE; live/held counters=0; sync regs s1,s2,s3=0; all outputs 0.
//  Edge detect: s1<=tick_in, s2<=s1, s3<=s2; edge=s2&~s3.
//   - Runs in every state, so a stale level never creates a false edge on resume.
//   - Counter updates on the cycle after edge; disp_* changes 4 clk after tick_in rises (RUN).
//  Counting, on edge in RUN or LAP only:
//   - ms+1; at MS_MAX ms->0 and sec+1; at SEC_MAX sec->0 and min+1.
//   - At MIN_MAX:SEC_MAX:MS_MAX all->0, wrap=1 for exactly 1 cycle.
//   - Edges in IDLE/PAUSED are discarded, not queued.
//  FSM, priority clear > start_stop > lap:
//   - IDLE:   start_stop->RUN.
//   - RUN:    start_stop->PAUSED; lap->LAP (held<=live, same cycle).
//   - LAP:    counting continues, disp_* shows held; lap->RUN; start_stop->PAUSED.
//   - PAUSED: start_stop->RUN; lap ignored.
//   - any state: clear->IDLE, live=held=0, pending edge that cycle dropped.
//  Display mux:
//   - disp_* = held in LAP, else live; registered, 1-cycle lag from selection change.
//   - lap_active/running registered from next state; assert 1 cycle after command pulse.
//  Simultaneous events:
//   - edge with start_stop in RUN: edge counted, then pause.
//   - edge with lap in RUN: held gets pre-increment value.
//   - edge with clear: clear wins, counters 0.
//  rst mid-count: next cycle identical to power-on reset state.
//  Outputs never exceed MS_MAX/SEC_MAX/MIN_MAX.
// TESTING
//  1 rst, start_stop, 1000 tick periods -> disp 00:01.000, running=1, no wrap.
//  2 Preload live=59:59.998 via force, RUN, 2 ticks -> 59:59.999 then 00:00.000, wrap=1 for 1 cycle.
//  3 RUN 250 ticks, lap, 100 ticks -> disp stays 00:00.250, lap_active=1; lap -> disp 00:00.350.
//  4 RUN 10 ticks, start_stop, 50 ticks, start_stop, 5 ticks -> disp 00:00.015.
//  5 clear and tick edge same cycle in RUN at 00:00.123 -> 00:00.000, IDLE, running=0.
//  6 tick_in held high through rst release and 3 start_stop toggles -> no count until next rising edge.

Source files
------------

// File: rtl/ms_stopwatch.sv
// rtl/ms_stopwatch.sv - min:sec:ms stopwatch driven by a synchronised 1 kHz timebase
module ms_stopwatch #(
    parameter int MS_MAX  = 999,
    parameter int SEC_MAX = 59,
    parameter int MIN_MAX = 59
) (
    input  logic       clk_27Mhz,
    input  logic       rst,
    input  logic       tick_in,
    input  logic       start_stop,
    input  logic       lap,
    input  logic       clear,
    output logic [9:0] disp_ms,
    output logic [5:0] disp_sec,
    output logic [5:0] disp_min,
    output logic       running,
    output logic       lap_active,
    output logic       wrap
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        LAP    = 2'd2,
        PAUSED = 2'd3
    } state_t;

    localparam logic [9:0] MS_LAST  = 10'(MS_MAX);
    localparam logic [5:0] SEC_LAST = 6'(SEC_MAX);
    localparam logic [5:0] MIN_LAST = 6'(MIN_MAX);

    state_t     r_state;
    logic       r_s1, r_s2, r_s3;
    logic [9:0] r_live_ms;
    logic [5:0] r_live_sec, r_live_min;
    logic [9:0] r_held_ms;
    logic [5:0] r_held_sec, r_held_min;
    logic [9:0] r_disp_ms;
    logic [5:0] r_disp_sec, r_disp_min;
    logic       r_running, r_lap_active, r_wrap;

    logic       w_edge;
    logic       w_counting;

    // The edge is taken from the two later stages so s1 absorbs metastability.
    assign w_edge     = r_s2 & ~r_s3;
    // Edges outside RUN/LAP are simply dropped; clear also drops a coincident edge.
    assign w_counting = w_edge & ~clear & ((r_state == RUN) || (r_state == LAP));

    // Three-stage synchroniser, always running so a resume never sees a stale edge
    always_ff @(posedge clk_27Mhz) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= tick_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Control FSM: clear beats start_stop beats lap; status flags follow the next state
    always_ff @(posedge clk_27Mhz) begin
        if (rst || clear) begin
            r_state      <= IDLE;
            r_running    <= 1'b0;
            r_lap_active <= 1'b0;
            r_held_ms    <= '0;
            r_held_sec   <= '0;
            r_held_min   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_stop) begin
                        r_state   <= RUN;
                        r_running <= 1'b1;
                    end
                end
                RUN: begin
                    if (start_stop) begin
                        r_state   <= PAUSED;
                        r_running <= 1'b0;
                    end else if (lap) begin
                        // Snapshot is the pre-increment value if an edge lands this cycle
                        r_state      <= LAP;
                        r_lap_active <= 1'b1;
                        r_held_ms    <= r_live_ms;
                        r_held_sec   <= r_live_sec;
                        r_held_min   <= r_live_min;
                    end
                end
                LAP: begin
                    if (start_stop) begin
                        r_state      <= PAUSED;
                        r_running    <= 1'b0;
                        r_lap_active <= 1'b0;
                    end else if (lap) begin
                        r_state      <= RUN;
                        r_lap_active <= 1'b0;
                    end
                end
                PAUSED: begin
                    if (start_stop) begin
                        r_state   <= RUN;
                        r_running <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_running    <= 1'b0;
                    r_lap_active <= 1'b0;
                end
            endcase
        end
    end

    // Live ms/sec/min cascade with a single-cycle wrap pulse on full roll-over
    always_ff @(posedge clk_27Mhz) begin
        if (rst || clear) begin
            r_live_ms  <= '0;
            r_live_sec <= '0;
            r_live_min <= '0;
            r_wrap     <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (w_counting) begin
                if (r_live_ms != MS_LAST) begin
                    r_live_ms <= r_live_ms + 10'd1;
                end else begin
                    r_live_ms <= '0;
                    if (r_live_sec != SEC_LAST) begin
                        r_live_sec <= r_live_sec + 6'd1;
                    end else begin
                        r_live_sec <= '0;
                        if (r_live_min != MIN_LAST) begin
                            r_live_min <= r_live_min + 6'd1;
                        end else begin
                            r_live_min <= '0;
                            r_wrap     <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Display register: frozen snapshot while in LAP, live count otherwise
    always_ff @(posedge clk_27Mhz) begin
        if (rst) begin
            r_disp_ms  <= '0;
            r_disp_sec <= '0;
            r_disp_min <= '0;
        end else if (r_state == LAP) begin
            r_disp_ms  <= r_held_ms;
            r_disp_sec <= r_held_sec;
            r_disp_min <= r_held_min;
        end else begin
            r_disp_ms  <= r_live_ms;
            r_disp_sec <= r_live_sec;
            r_disp_min <= r_live_min;
        end
    end

    assign disp_ms    = r_disp_ms;
    assign disp_sec   = r_disp_sec;
    assign disp_min   = r_disp_min;
    assign running    = r_running;
    assign lap_active = r_lap_active;
    assign wrap       = r_wrap;

endmodule

// File: tb/tb_ms_stopwatch.sv
// tb/tb_ms_stopwatch.sv - scoreboard testbench for ms_stopwatch
module tb_ms_stopwatch;

    logic       clk_27Mhz = 1'b0;
    logic       rst = 1'b1;
    logic       tick_in = 1'b0;
    logic       start_stop = 1'b0;
    logic       lap = 1'b0;
    logic       clear = 1'b0;
    logic [9:0] disp_ms;
    logic [5:0] disp_sec;
    logic [5:0] disp_min;
    logic       running;
    logic       lap_active;
    logic       wrap;

    int          n_total = 0;
    int          n_pass  = 0;
    int          wrap_seen = 0;
    logic [23:0] exp_q[$];
    logic [23:0] e;
    logic [23:0] obs;

    assign obs = {disp_min, disp_sec, disp_ms, running, lap_active};

    ms_stopwatch dut (
        .clk_27Mhz (clk_27Mhz),
        .rst       (rst),
        .tick_in   (tick_in),
        .start_stop(start_stop),
        .lap       (lap),
        .clear     (clear),
        .disp_ms   (disp_ms),
        .disp_sec  (disp_sec),
        .disp_min  (disp_min),
        .running   (running),
        .lap_active(lap_active),
        .wrap      (wrap)
    );

    always #5 clk_27Mhz = ~clk_27Mhz;

    always @(negedge clk_27Mhz) begin
        if (wrap === 1'b1) wrap_seen++;
    end

    function automatic logic [23:0] mk(int mn, int sc, int ms, bit run, bit lp);
        return {6'(mn), 6'(sc), 10'(ms), run, lp};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk_27Mhz);
        rst = 1'b0;
        @(negedge clk_27Mhz);
    endtask

    task automatic pulse_ss();
        start_stop = 1'b1;
        @(negedge clk_27Mhz);
        start_stop = 1'b0;
        @(negedge clk_27Mhz);
    endtask

    task automatic pulse_lap();
        lap = 1'b1;
        @(negedge clk_27Mhz);
        lap = 1'b0;
        @(negedge clk_27Mhz);
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) begin
            tick_in = 1'b1;
            repeat (4) @(negedge clk_27Mhz);
            tick_in = 1'b0;
            repeat (4) @(negedge clk_27Mhz);
        end
    endtask

    // Rising tick edge with a command landing on the same cycle the edge is seen
    task automatic edge_with(int which);
        tick_in = 1'b1;
        repeat (2) @(negedge clk_27Mhz);
        if (which == 0) start_stop = 1'b1;
        else if (which == 1) lap = 1'b1;
        else clear = 1'b1;
        @(negedge clk_27Mhz);
        start_stop = 1'b0;
        lap = 1'b0;
        clear = 1'b0;
        repeat (2) @(negedge clk_27Mhz);
        tick_in = 1'b0;
        repeat (4) @(negedge clk_27Mhz);
    endtask

    task automatic test_reset();
        do_reset();
        exp_q.push_back(mk(0, 0, 0, 0, 0));
        e = exp_q.pop_front();
        n_total++;
        if (obs !== e || wrap !== 1'b0) $display("FAIL reset: got %h wrap=%b expected %h wrap=0", obs, wrap, e);
        else n_pass++;
    endtask

    task automatic test_latency();
        do_reset();
        pulse_ss();
        exp_q.push_back(mk(0, 0, 0, 1, 0));
        exp_q.push_back(mk(0, 0, 1, 1, 0));
        tick_in = 1'b1;
        repeat (3) @(posedge clk_27Mhz);
        @(negedge clk_27Mhz);
        e = exp_q.pop_front();
        n_total++;
        if (obs !== e) $display("FAIL latency_3clk: got %h expected %h", obs, e);
        else n_pass++;
        @(negedge clk_27Mhz);
        e = exp_q.pop_front();
        n_total++;
        if (obs !== e) $display("FAIL latency_4clk: got %h expected %h", obs, e);
        else n_pass++;
        tick_in = 1'b0;
        repeat (4) @(negedge clk_27Mhz);
    endtask

    task automatic test_one_second();
        int w0;
        do_reset();
        w0 = wrap_seen;
        pulse_ss();
        exp_q.push_back(mk(0, 1, 0, 1, 0));
        ticks(1000);
        e = exp_q.pop_front();
        n_total++;
        if (obs !== e) $display("FAIL one_second: got %h expected %h", obs, e);
        else n_pass++;
        n_total++;
        if (wrap_seen - w0 !== 0) $display("FAIL one_second_wrap: got %0d pulses expected 0", wrap_seen - w0);
        else n_pass++;
    endtask

    task automatic test_wrap();
        int w0;
        do_reset();
        force dut.r_live_ms  = 10'd998;
        force dut.r_live_sec = 6'd59;
        force dut.r_live_min = 6'd59;
        @(negedge clk_27Mhz);
        release dut.r_live_ms;
        release dut.r_live_sec;
        release dut.r_live_min;
        @(negedge clk_27Mhz);
        exp_q.push_back(mk(59, 59, 998, 0, 0));
        e = exp_q.pop_front();
        n_total++;
        if (obs !== e) $display("FAIL wrap_preload: got %h expected %h", obs, e);
        else n_pass++;
        w0 = wrap_seen;
        pulse_ss();
        exp_q.push_back(mk(59, 59, 999, 1, 0));
        ticks(1);
        e = exp_q.pop_front();
        n_total++;
        if (obs !== e) $display("FAIL wrap_999: got %h expected %h", obs, e);
        else n_pass++;
        exp_q.push_back(mk(0, 0, 0, 1, 0));
        ticks(1);
        e = exp_q.pop_front();
        n_total++;
        if (obs !== e) $display("FAIL wrap_zero: got %h expected %h", obs, e);
        else n_pass++;
        n_total++;
        if (wrap_seen - w0 !== 1) $display("FAIL wrap_pulse: got %0d high cycles expected 1", wrap_seen - w0);
        else n_pass++;
    endtask

    task automatic test_lap();
        do_reset();
        pulse_ss();
        ticks(250);
        pulse_lap();
        exp_q.push_back(mk(0, 0, 250, 1, 1));
        exp_q.push_back(mk(0, 0, 250, 1, 1));
        exp_q.push_back(mk(0, 0, 350, 1, 0));
        e = exp_q.pop_front();
        n_total++;
        if (obs !== e) $display("FAIL lap_enter: got %h expected %h", obs, e);
        else n_pass++;
        ticks(100);
        e = exp_q.pop_front();
        n_total++;
        if (obs !== e) $display("FAIL lap_frozen: got %h expected %h", obs, e);
        else n_pass++;
        pulse_lap();
        e = exp_q.pop_front();
        n_total++;
        if (obs !== e) $display("FAIL lap_exit: got %h expected %h", obs, e);
        else n_pass++;
    endtask

    task automatic test_pause();
        do_reset();
        pulse_ss();
        ticks(10);
        pulse_ss();
        exp_q.push_back(mk(0, 0, 10, 0, 0));
        ticks(50);
        e = exp_q.pop_front();
        n_total++;
        if (obs !== e) $display("FAIL pause_hold: got %h expected %h", obs, e);
        else n_pass++;
        pulse_ss();
        exp_q.push_back(mk(0, 0, 15, 1, 0));
        ticks(5);
        e = exp_q.pop_front();
        n_total++;
        if (obs !== e) $display("FAIL pause_resume: got %h expected %h", obs, e);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        do_reset();
        pulse_ss();
        ticks(5);
        exp_q.push_back(mk(0, 0, 6, 0, 0));
        edge_with(0);
        e = exp_q.pop_front();
        n_total++;
        if (obs !== e) $display("FAIL edge_with_ss: got %h expected %h", obs, e);
        else n_pass++;
        pulse_ss();
        exp_q.push_back(mk(0, 0, 6, 1, 1));
        edge_with(1);
        e = exp_q.pop_front();
        n_total++;
        if (obs !== e) $display("FAIL edge_with_lap: got %h expected %h", obs, e);
        else n_pass++;
        pulse_lap();
        exp_q.push_back(mk(0, 0, 7, 1, 0));
        e = exp_q.pop_front();
        n_total++;
        if (obs !== e) $display("FAIL edge_with_lap_live: got %h expected %h", obs, e);
        else n_pass++;
    endtask

    task automatic test_clear_edge();
        do_reset();
        pulse_ss();
        ticks(123);
        exp_q.push_back(mk(0, 0, 0, 0, 0));
        edge_with(2);
        e = exp_q.pop_front();
        n_total++;
        if (obs !== e) $display("FAIL clear_with_edge: got %h expected %h", obs, e);
        else n_pass++;
    endtask

    task automatic test_high_through_reset();
        tick_in = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk_27Mhz);
        rst = 1'b0;
        repeat (4) @(negedge clk_27Mhz);
        pulse_ss();
        pulse_ss();
        pulse_ss();
        repeat (4) @(negedge clk_27Mhz);
        exp_q.push_back(mk(0, 0, 0, 1, 0));
        e = exp_q.pop_front();
        n_total++;
        if (obs !== e) $display("FAIL high_no_count: got %h expected %h", obs, e);
        else n_pass++;
        tick_in = 1'b0;
        repeat (4) @(negedge clk_27Mhz);
        exp_q.push_back(mk(0, 0, 1, 1, 0));
        ticks(1);
        e = exp_q.pop_front();
        n_total++;
        if (obs !== e) $display("FAIL high_next_edge: got %h expected %h", obs, e);
        else n_pass++;
    endtask

    task automatic test_rst_mid();
        do_reset();
        pulse_ss();
        ticks(7);
        pulse_lap();
        tick_in = 1'b1;
        @(negedge clk_27Mhz);
        rst = 1'b1;
        @(negedge clk_27Mhz);
        exp_q.push_back(mk(0, 0, 0, 0, 0));
        e = exp_q.pop_front();
        n_total++;
        if (obs !== e || wrap !== 1'b0) $display("FAIL rst_mid: got %h wrap=%b expected %h wrap=0", obs, wrap, e);
        else n_pass++;
        tick_in = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk_27Mhz);
    endtask

    initial begin
        @(negedge clk_27Mhz);
        test_reset();
        test_latency();
        test_one_second();
        test_wrap();
        test_lap();
        test_pause();
        test_simultaneous();
        test_clear_edge();
        test_high_through_reset();
        test_rst_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
